// File: rtl/mem_access_sequencer.sv
// Single-word Avalon-MM master sequencer: one read or write per level-handshaked request,
// with a bus-wait watchdog that always returns control to the requester.
module mem_access_sequencer #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                soft_reset,
    input  logic [1:0]          mode,
    input  logic                io_done,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   write_data,
    output logic                mem_done,
    output logic [DATA_W-1:0]   read_data,
    output logic                error,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_DATA, S_WR_REQ, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              error_q, error_d;
    logic              done_q, done_d;

    logic rd_req, wr_req, busy, timeout_hit, capture, abort;

    assign rd_req      = io_done && (mode == 2'b01);
    assign wr_req      = io_done && (mode == 2'b10);
    assign busy        = (state_q == S_RD_REQ) || (state_q == S_RD_DATA) || (state_q == S_WR_REQ);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign capture     = ((state_q == S_RD_REQ) && !avm_waitrequest && avm_readdatavalid) ||
                         ((state_q == S_RD_DATA) && avm_readdatavalid);
    // Completion takes priority over the watchdog when both land in the same cycle.
    assign abort       = timeout_hit &&
                         (((state_q == S_RD_REQ)  && avm_waitrequest)    ||
                          ((state_q == S_RD_DATA) && !avm_readdatavalid) ||
                          ((state_q == S_WR_REQ)  && avm_waitrequest));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else if (soft_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req)      state_d = S_RD_REQ;
                else if (wr_req) state_d = S_WR_REQ;
            end
            S_RD_REQ: begin
                if (!avm_waitrequest) state_d = avm_readdatavalid ? S_DONE : S_RD_DATA;
                else if (abort)       state_d = S_DONE;
            end
            S_RD_DATA: begin
                if (avm_readdatavalid || abort) state_d = S_DONE;
            end
            S_WR_REQ: begin
                if (!avm_waitrequest || abort) state_d = S_DONE;
            end
            S_DONE: begin
                if (!io_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        if (busy && (state_d == state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
            addr_d  = address;
            error_d = 1'b0;
            if (state_d == S_WR_REQ) wdata_d = write_data;
        end
        if (capture) rdata_d = avm_readdata;
        if (abort) begin
            error_d = 1'b1;
            if (state_q != S_WR_REQ) rdata_d = '0;
        end
        read_d  = (state_d == S_RD_REQ);
        write_d = (state_d == S_WR_REQ);
        be_d    = (read_d || write_d) ? {BE_W{1'b1}} : '0;
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            be_q    <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (soft_reset) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            be_q    <= '0;
            error_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            read_q  <= read_d;
            write_q <= write_d;
            be_q    <= be_d;
            error_q <= error_d;
            done_q  <= done_d;
        end
    end

    assign mem_done       = done_q;
    assign read_data      = rdata_q;
    assign error          = error_q;
    assign avm_address    = addr_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: reset, read with stalls, write, zero-latency read,
// watchdog timeout, no-op mode and soft reset.
module tb_mem_access_sequencer;
    localparam int ADDR_W  = 25;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic                clk;
    logic                rst_n;
    logic                soft_reset;
    logic [1:0]          mode;
    logic                io_done;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   write_data;
    logic                mem_done;
    logic [DATA_W-1:0]   read_data;
    logic                error;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_read;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;

    int vectors;
    int miscompares;

    mem_access_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .soft_reset        (soft_reset),
        .mode              (mode),
        .io_done           (io_done),
        .address           (address),
        .write_data        (write_data),
        .mem_done          (mem_done),
        .read_data         (read_data),
        .error             (error),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge; inputs set afterwards hit the next edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; soft_reset = 1'b0; mode = 2'b00; io_done = 1'b0;
        address = '0; write_data = '0; avm_waitrequest = 1'b0;
        avm_readdata = '0; avm_readdatavalid = 1'b0;
        step; step;
        vectors++;
        if ({mem_done, avm_read, avm_write, error, avm_byteenable} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000", {mem_done, avm_read, avm_write, error, avm_byteenable});
        end
        vectors++;
        if ({avm_address, avm_writedata, read_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%h wd=%h rd=%h expected all 0", avm_address, avm_writedata, read_data);
        end
        rst_n = 1'b1;
        step;
        address = 25'h0AAAAAA; mode = 2'b01; io_done = 1'b1; avm_waitrequest = 1'b1;
        step;
        vectors++;
        if (avm_read !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pre_read: got %b expected 1", avm_read);
        end
        step;
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if ({avm_read, avm_byteenable, mem_done} !== 4'b0 || avm_address !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got rd=%b be=%b done=%b addr=%h expected all 0", avm_read, avm_byteenable, mem_done, avm_address);
        end
        io_done = 1'b0; mode = 2'b00; avm_waitrequest = 1'b0;
        step;
        rst_n = 1'b1;
        step; step;
        vectors++;
        if ({avm_read, avm_write, mem_done} !== 3'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got rd=%b wr=%b done=%b expected 000", avm_read, avm_write, mem_done);
        end
    endtask

    task automatic test_read_stall;
        address = 25'h1ABCDEF; mode = 2'b01; io_done = 1'b1; avm_waitrequest = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step;
            vectors++;
            if (avm_read !== 1'b1 || avm_address !== 25'h1ABCDEF || avm_byteenable !== 2'b11) begin
                miscompares++;
                $display("FAIL rd_cmd_cycle%0d: got rd=%b addr=%h be=%b expected 1 1abcdef 11", c, avm_read, avm_address, avm_byteenable);
            end
            if (c == 4) avm_waitrequest = 1'b0;
        end
        step;
        vectors++;
        if (avm_read !== 1'b0 || avm_byteenable !== 2'b00 || mem_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_accepted: got rd=%b be=%b done=%b expected 0 00 0", avm_read, avm_byteenable, mem_done);
        end
        step;
        vectors++;
        if (mem_done !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_wait_valid: got done=%b expected 0", mem_done);
        end
        avm_readdatavalid = 1'b1; avm_readdata = 16'hBEEF;
        step;
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        vectors++;
        if (mem_done !== 1'b1 || read_data !== 16'hBEEF || error !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_done: got done=%b data=%h err=%b expected 1 beef 0", mem_done, read_data, error);
        end
        io_done = 1'b0;
        step;
        vectors++;
        if (mem_done !== 1'b0 || read_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rd_release: got done=%b data=%h expected 0 beef", mem_done, read_data);
        end
    endtask

    task automatic test_write;
        address = 25'h0000012; write_data = 16'h1234; mode = 2'b10; io_done = 1'b1; avm_waitrequest = 1'b0;
        step;
        vectors++;
        if (avm_write !== 1'b1 || avm_read !== 1'b0 || avm_byteenable !== 2'b11 ||
            avm_address !== 25'h0000012 || avm_writedata !== 16'h1234) begin
            miscompares++;
            $display("FAIL wr_cmd: got wr=%b rd=%b be=%b addr=%h wd=%h expected 1 0 11 0000012 1234",
                     avm_write, avm_read, avm_byteenable, avm_address, avm_writedata);
        end
        step;
        vectors++;
        if (avm_write !== 1'b0 || mem_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_done: got wr=%b done=%b expected 0 1", avm_write, mem_done);
        end
        for (int c = 1; c <= 5; c++) begin
            step;
            vectors++;
            if (avm_write !== 1'b0 || avm_read !== 1'b0 || mem_done !== 1'b1) begin
                miscompares++;
                $display("FAIL wr_hold%0d: got wr=%b rd=%b done=%b expected 0 0 1", c, avm_write, avm_read, mem_done);
            end
        end
        vectors++;
        if (read_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL wr_keeps_rdata: got %h expected beef", read_data);
        end
        io_done = 1'b0; mode = 2'b00;
        step;
        vectors++;
        if (mem_done !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_release: got done=%b expected 0", mem_done);
        end
    endtask

    task automatic test_zero_latency_read;
        address = 25'h0000100; mode = 2'b01; io_done = 1'b1; avm_waitrequest = 1'b0;
        step;
        vectors++;
        if (avm_read !== 1'b1) begin
            miscompares++;
            $display("FAIL zl_cmd: got rd=%b expected 1", avm_read);
        end
        avm_readdatavalid = 1'b1; avm_readdata = 16'h00FF;
        step;
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        vectors++;
        if (avm_read !== 1'b0 || mem_done !== 1'b1 || read_data !== 16'h00FF) begin
            miscompares++;
            $display("FAIL zl_done: got rd=%b done=%b data=%h expected 0 1 00ff", avm_read, mem_done, read_data);
        end
        vectors++;
        if (avm_writedata !== 16'h1234) begin
            miscompares++;
            $display("FAIL zl_keeps_wdata: got %h expected 1234", avm_writedata);
        end
        io_done = 1'b0; mode = 2'b00;
        step;
    endtask

    task automatic test_timeout;
        address = 25'h0000200; mode = 2'b01; io_done = 1'b1; avm_waitrequest = 1'b1;
        for (int c = 1; c <= TIMEOUT; c++) begin
            step;
            vectors++;
            if (avm_read !== 1'b1 || mem_done !== 1'b0) begin
                miscompares++;
                $display("FAIL to_wait%0d: got rd=%b done=%b expected 1 0", c, avm_read, mem_done);
            end
        end
        step;
        vectors++;
        if (avm_read !== 1'b0 || error !== 1'b1 || read_data !== 16'h0000 || mem_done !== 1'b1) begin
            miscompares++;
            $display("FAIL to_abort: got rd=%b err=%b data=%h done=%b expected 0 1 0000 1", avm_read, error, read_data, mem_done);
        end
        avm_readdatavalid = 1'b1; avm_readdata = 16'hDEAD;
        step;
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        vectors++;
        if (read_data !== 16'h0000 || mem_done !== 1'b1 || error !== 1'b1) begin
            miscompares++;
            $display("FAIL to_late_valid: got data=%h done=%b err=%b expected 0000 1 1", read_data, mem_done, error);
        end
        io_done = 1'b0; mode = 2'b00;
        step;
        address = 25'h0000300; write_data = 16'hA5A5; mode = 2'b10; io_done = 1'b1; avm_waitrequest = 1'b0;
        step;
        vectors++;
        if (error !== 1'b0 || avm_write !== 1'b1) begin
            miscompares++;
            $display("FAIL to_recover: got err=%b wr=%b expected 0 1", error, avm_write);
        end
        step;
        vectors++;
        if (mem_done !== 1'b1 || error !== 1'b0 || read_data !== 16'h0000) begin
            miscompares++;
            $display("FAIL to_recover_done: got done=%b err=%b data=%h expected 1 0 0000", mem_done, error, read_data);
        end
        io_done = 1'b0; mode = 2'b00;
        step;
    endtask

    task automatic test_noop_and_soft_reset;
        mode = 2'b11; io_done = 1'b1; address = 25'h0000400;
        for (int c = 1; c <= 3; c++) begin
            step;
            vectors++;
            if ({avm_read, avm_write, mem_done, avm_byteenable} !== 5'b0) begin
                miscompares++;
                $display("FAIL noop%0d: got rd=%b wr=%b done=%b be=%b expected all 0", c, avm_read, avm_write, mem_done, avm_byteenable);
            end
        end
        mode = 2'b01; avm_waitrequest = 1'b0;
        step;
        avm_readdatavalid = 1'b1; avm_readdata = 16'h5A5A;
        step;
        avm_readdatavalid = 1'b0; avm_readdata = '0;
        vectors++;
        if (mem_done !== 1'b1 || read_data !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL sr_pre_done: got done=%b data=%h expected 1 5a5a", mem_done, read_data);
        end
        soft_reset = 1'b1;
        step;
        soft_reset = 1'b0; io_done = 1'b0; mode = 2'b00;
        vectors++;
        if (mem_done !== 1'b0 || read_data !== '0 || avm_writedata !== '0 || avm_address !== '0) begin
            miscompares++;
            $display("FAIL sr_clear: got done=%b data=%h wd=%h addr=%h expected 0 0 0 0", mem_done, read_data, avm_writedata, avm_address);
        end
        step;
        vectors++;
        if ({mem_done, avm_read, avm_write} !== 3'b0) begin
            miscompares++;
            $display("FAIL sr_idle: got done=%b rd=%b wr=%b expected 000", mem_done, avm_read, avm_write);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_read_stall;
        test_write;
        test_zero_latency_read;
        test_timeout;
        test_noop_and_soft_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
